// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register bank with scoreboard.
// Provides the default widths, the register count and a helper that
// recognises the hardwired-zero register.
// No ports: package only.
package mips_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

   // Register 0 is hardwired: never written, never pending, always reads 0.
   function automatic logic is_zero(input logic [ADDR_W_DEF-1:0] addr);
      return (addr == REG_ZERO);
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Scoreboard for the register bank: tracks which registers have an
// outstanding producer and raises a stall on read-after-write hazards.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   i_issueValid, i_issueDst    instruction issuing with a register destination
//   i_wbEn, i_wbAddr            write-back strobe and destination
//   i_rsAddr, i_rtAddr          decode-stage source addresses
//   i_rsUsed, i_rtUsed          instruction actually consumes rs / rt
//   o_stall                     combinational RAW hazard indication
//   o_pendingCnt                registered count of pending registers
module reg_scoreboard
   import mips_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_issueValid,
   input  logic [ADDR_W-1:0] i_issueDst,
   input  logic              i_wbEn,
   input  logic [ADDR_W-1:0] i_wbAddr,
   input  logic [ADDR_W-1:0] i_rsAddr,
   input  logic [ADDR_W-1:0] i_rtAddr,
   input  logic              i_rsUsed,
   input  logic              i_rtUsed,
   output logic              o_stall,
   output logic [ADDR_W:0]   o_pendingCnt
);

   localparam int              NumRegs = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] MaxCnt  = (ADDR_W + 1)'(NumRegs - 1);

   logic [NumRegs-1:0] r_pending;
   logic [ADDR_W:0]    r_pendingCnt;

   logic w_pendEffRs;
   logic w_pendEffRt;
   logic w_stall;
   logic w_doIssue;
   logic w_doWb;
   logic w_inc;
   logic w_dec;

   // Hazard detection and the set/clear decisions for this cycle.
   // A write-back landing this cycle resolves the hazard on its register,
   // since the bank bypasses the written value straight to the read port.
   // The count moves by +1 only when an issue sets a clear bit, and by -1
   // only when a write-back clears a set bit that is not being re-claimed
   // by a same-cycle issue (the new producer keeps the register pending).
   always_comb begin
      w_pendEffRs = 1'b0;
      w_pendEffRt = 1'b0;
      w_stall     = 1'b0;
      w_doIssue   = 1'b0;
      w_doWb      = 1'b0;
      w_inc       = 1'b0;
      w_dec       = 1'b0;

      w_pendEffRs = r_pending[i_rsAddr] & ~(i_wbEn & (i_wbAddr == i_rsAddr));
      w_pendEffRt = r_pending[i_rtAddr] & ~(i_wbEn & (i_wbAddr == i_rtAddr));
      w_stall     = (i_rsUsed & w_pendEffRs) | (i_rtUsed & w_pendEffRt);

      w_doWb    = i_wbEn & ~is_zero(i_wbAddr);
      w_doIssue = i_issueValid & ~w_stall & ~is_zero(i_issueDst);

      w_inc = w_doIssue & ~r_pending[i_issueDst];
      w_dec = w_doWb & r_pending[i_wbAddr] &
              ~(w_doIssue & (i_issueDst == i_wbAddr));
   end

   // Pending vector and its running popcount. The issue assignment comes
   // after the write-back clear so a same-register collision stays pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending    <= '0;
         r_pendingCnt <= '0;
      end else begin
         if (w_doWb) begin
            r_pending[i_wbAddr] <= 1'b0;
         end
         if (w_doIssue) begin
            r_pending[i_issueDst] <= 1'b1;
         end
         if (w_inc && !w_dec && (r_pendingCnt != MaxCnt)) begin
            r_pendingCnt <= r_pendingCnt + 1'b1;
         end else if (w_dec && !w_inc && (r_pendingCnt != '0)) begin
            r_pendingCnt <= r_pendingCnt - 1'b1;
         end
      end
   end

   assign o_stall      = w_stall;
   assign o_pendingCnt = r_pendingCnt;

endmodule

// File: rtl/register_file_sb.sv
// MIPS register bank with scoreboard. Holds the register array, serves two
// combinational read ports with same-cycle write-through bypass and forces
// register 0 to read as zero. Hazard tracking lives in reg_scoreboard.
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   rs_addr/rs_data, rt_addr/rt_data decode-stage read ports
//   rs_used, rt_used                 instruction consumes rs / rt
//   issue_valid, issue_dst           issuing instruction and its RegDst destination
//   wb_en, wb_addr, wb_data          write-back port
//   stall                            RAW hazard, hold issue this cycle
//   pending_cnt                      number of registers currently pending
module register_file_sb
   import mips_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              rs_used,
   input  logic              rt_used,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_dst,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall,
   output logic [ADDR_W:0]   pending_cnt
);

   localparam int NumRegs = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_regs [NumRegs];

   logic              w_stall;
   logic [ADDR_W:0]   w_pendingCnt;

   // Register array. Writes to register 0 are dropped so it stays zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NumRegs; i++) begin
            r_regs[i] <= '0;
         end
      end else if (wb_en && !is_zero(wb_addr)) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   // Read port A: zero register first, then the write-back bypass so a
   // consumer in the same cycle sees the value being written.
   always_comb begin
      rs_data = r_regs[rs_addr];
      if (is_zero(rs_addr)) begin
         rs_data = '0;
      end else if (wb_en && (wb_addr == rs_addr)) begin
         rs_data = wb_data;
      end
   end

   // Read port B: same priority as port A.
   always_comb begin
      rt_data = r_regs[rt_addr];
      if (is_zero(rt_addr)) begin
         rt_data = '0;
      end else if (wb_en && (wb_addr == rt_addr)) begin
         rt_data = wb_data;
      end
   end

   reg_scoreboard #(
      .ADDR_W(ADDR_W)
   ) u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .i_issueValid (issue_valid),
      .i_issueDst   (issue_dst),
      .i_wbEn       (wb_en),
      .i_wbAddr     (wb_addr),
      .i_rsAddr     (rs_addr),
      .i_rtAddr     (rt_addr),
      .i_rsUsed     (rs_used),
      .i_rtUsed     (rt_used),
      .o_stall      (w_stall),
      .o_pendingCnt (w_pendingCnt)
   );

   assign stall       = w_stall;
   assign pending_cnt = w_pendingCnt;

endmodule
